// File: rtl/median_filter_pkg.sv
// median_filter_pkg: shared pixel type, frame-control states and expected output count
package median_filter_pkg;
  typedef logic [7:0] pixel_t;
  typedef enum logic [2:0] {IDLE, CLEAR, STREAM, CHECK, DONE} state_t;
  // A filter with a 2x2 footprint emits one result per window, not per pixel
  function automatic int unsigned expected_out(input int unsigned len, input int unsigned height);
    return (len - 1) * (height - 1);
  endfunction
endpackage

// File: rtl/pixel_valid_if.sv
// pixel_valid_if: pixel plus valid strobe between stream stages
interface pixel_valid_if;
  import median_filter_pkg::*;
  pixel_t pixel;
  logic valid;
  modport master (output pixel, output valid);
  modport slave (input pixel, input valid);
endinterface

// File: rtl/median_frame_ctrl.sv
// median_frame_ctrl: gates one frame of pixels into the median filter and checks its output count
module median_frame_ctrl
  import median_filter_pkg::*;
#(
  parameter int IMAGE_LEN    = 1080,
  parameter int IMAGE_HEIGHT = 720
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  pixel_valid_if.slave     src_if,
  pixel_valid_if.master    flt_if,
  input  logic             flt_valid_i,
  output logic             flt_rst_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);
  localparam int unsigned N  = IMAGE_LEN * IMAGE_HEIGHT;
  localparam int          CW = $clog2(N + 1);
  localparam logic [CW-1:0] N_C  = CW'(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [CW-1:0] EXP  = CW'(expected_out(IMAGE_LEN, IMAGE_HEIGHT));
  state_t        r_state, w_next;
  logic [CW-1:0] r_in_cnt, r_out_cnt;
  logic          r_err;
  logic          w_acc;
  assign w_acc         = src_if.valid && r_state == STREAM;
  assign flt_if.pixel  = src_if.pixel;
  assign flt_if.valid  = w_acc;
  assign err_o         = r_err;
  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end
  // Next-state and per-state outputs; the last accepted pixel moves straight to CHECK
  always_comb begin
    w_next    = r_state;
    busy_o    = 1'b0;
    done_o    = 1'b0;
    flt_rst_o = rst;
    case (r_state)
      IDLE:   w_next = start_i ? CLEAR : IDLE;
      CLEAR:  begin
        w_next    = STREAM;
        busy_o    = 1'b1;
        flt_rst_o = 1'b1;
      end
      STREAM: begin
        busy_o = 1'b1;
        w_next = (w_acc && r_in_cnt == LAST) ? CHECK : STREAM;
      end
      CHECK:  begin
        busy_o = 1'b1;
        w_next = DONE;
      end
      DONE:   begin
        done_o = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end
  // Saturating input/output counters, live only while streaming
  always_ff @(posedge clk) begin
    if (rst || r_state == CLEAR) begin
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
    end else if (r_state == STREAM) begin
      if (w_acc && r_in_cnt != N_C) r_in_cnt <= r_in_cnt + CW'(1);
      if (flt_valid_i && r_out_cnt != '1) r_out_cnt <= r_out_cnt + CW'(1);
    end
  end
  // Sticky count-mismatch flag, cleared only by reset or a new frame
  always_ff @(posedge clk) begin
    if (rst || r_state == CLEAR) r_err <= 1'b0;
    else if (r_state == CHECK && r_out_cnt != EXP) r_err <= 1'b1;
  end
endmodule

// File: tb/tb_median_frame_ctrl.sv
// tb_median_frame_ctrl: scoreboard bench for the frame controller with a 4x3 image
module tb_median_frame_ctrl;
  import median_filter_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_i = 1'b0;
  logic flt_valid_i, flt_rst_o, busy_o, done_o, err_o;
  logic model_en = 1'b1;
  int   fwd_idx = 0;
  int   n_chk = 0, n_err = 0, n_done = 0, n_frst = 0;
  pixel_t sbq[$];
  pixel_valid_if src();
  pixel_valid_if flt();
  median_frame_ctrl #(.IMAGE_LEN(4), .IMAGE_HEIGHT(3)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .src_if(src), .flt_if(flt),
    .flt_valid_i(flt_valid_i), .flt_rst_o(flt_rst_o), .busy_o(busy_o),
    .done_o(done_o), .err_o(err_o)
  );
  always #5 clk = ~clk;
  // Filter model: a result for every pixel past the first row and first column
  assign flt_valid_i = model_en && flt.valid && fwd_idx >= 4 && (fwd_idx % 4) != 0;
  always @(posedge clk) begin
    if (flt_rst_o) fwd_idx <= 0;
    else if (flt.valid) fwd_idx <= fwd_idx + 1;
  end
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  // Output monitor: pops the scoreboard on every forwarded pixel
  always @(negedge clk) begin
    if (done_o) n_done++;
    if (flt_rst_o) n_frst++;
    if (flt.valid) begin
      if (sbq.size() == 0) chk("unexpected_fwd", 1, 0);
      else chk("fwd_pixel", int'(flt.pixel), int'(sbq.pop_front()));
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input pixel_t p, input bit fwd);
    src.pixel = p;
    src.valid = 1'b1;
    if (fwd) sbq.push_back(p);
    else chk("drop_fwd", int'(flt.valid), 0);
    tick();
    src.valid = 1'b0;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    src.valid = 1'b1;
    chk("rst_valid", int'(flt.valid), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_fltrst", int'(flt_rst_o), 0);
    chk("rst_err", int'(err_o), 0);
    src.valid = 1'b0;
  endtask
  task automatic run_frame(input int max_gap, input bit model, input bit exp_err, input bit poke);
    int d0, f0;
    d0 = n_done;
    f0 = n_frst;
    model_en = model;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("clear_fltrst", int'(flt_rst_o), 1);
    chk("clear_busy", int'(busy_o), 1);
    tick();
    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(max_gap)) tick();
      if (poke && i == 5) start_i = 1'b1;
      send(pixel_t'($urandom), 1'b1);
      start_i = 1'b0;
    end
    src.pixel = 8'hee;
    src.valid = 1'b1;
    chk("check_drop", int'(flt.valid), 0);
    chk("check_busy", int'(busy_o), 1);
    chk("check_done", int'(done_o), 0);
    tick();
    src.valid = 1'b0;
    chk("done_pulse", int'(done_o), 1);
    chk("done_busy", int'(busy_o), 0);
    if (poke) start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("idle_done", int'(done_o), 0);
    chk("frame_err", int'(err_o), int'(exp_err));
    tick();
    chk("start_ignored", int'(busy_o), 0);
    chk("done_count", n_done - d0, 1);
    chk("fltrst_count", n_frst - f0, 1);
    chk("sb_empty", sbq.size(), 0);
  endtask
  initial begin
    int d0;
    src.pixel = '0;
    src.valid = 1'b0;
    do_reset();
    run_frame(0, 1'b1, 1'b0, 1'b0);
    run_frame(3, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send(pixel_t'(i + 1), 1'b0);
    run_frame(0, 1'b1, 1'b0, 1'b0);
    run_frame(0, 1'b0, 1'b1, 1'b0);
    repeat (3) tick();
    chk("err_hold", int'(err_o), 1);
    do_reset();
    run_frame(1, 1'b0, 1'b1, 1'b0);
    run_frame(1, 1'b1, 1'b0, 1'b0);
    d0 = n_done;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    for (int i = 0; i < 7; i++) send(pixel_t'($urandom), 1'b1);
    do_reset();
    repeat (3) tick();
    chk("abort_no_done", n_done - d0, 0);
    run_frame(0, 1'b1, 1'b0, 1'b0);
    run_frame(2, 1'b1, 1'b0, 1'b1);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/median_frame_ctrl.md
MEDIAN_FRAME_CTRL -- requirements
Module: median_frame_ctrl

Interface
REQ-001 SHALL have parameter IMAGE_LEN, default 1080, pixels per line.
REQ-002 SHALL have parameter IMAGE_HEIGHT, default 720, lines per frame.
REQ-003 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port start_i, input, 1, one-cycle request to process one frame.
REQ-006 SHALL have port src_if, pixel_valid_if.slave, pixel+valid, pixel stream from the source.
REQ-007 SHALL have port flt_if, pixel_valid_if.master, pixel+valid, gated pixel stream to median_filter input.
REQ-008 SHALL have port flt_valid_i, input, 1, median_filter output valid, monitored.
REQ-009 SHALL have port flt_rst_o, output, 1, synchronous reset to median_filter, ORed with rst.
REQ-010 SHALL have port busy_o, output, 1, high while a frame is in progress.
REQ-011 SHALL have port done_o, output, 1, one-cycle pulse at frame completion.
REQ-012 SHALL have port err_o, output, 1, sticky output-count mismatch flag.

Function
REQ-013 SHALL implement FSM states IDLE, CLEAR, STREAM, CHECK, DONE.
REQ-014 IDLE: start_i=1 -> CLEAR; otherwise stay in IDLE.
REQ-015 CLEAR: flt_rst_o=1 for exactly one cycle; clear in_cnt and out_cnt; next state STREAM.
REQ-016 STREAM: flt_if.pixel=src_if.pixel and flt_if.valid=src_if.valid combinationally, zero latency.
REQ-017 Outside STREAM: flt_if.valid=0; source pixels dropped and not counted.
REQ-018 in_cnt SHALL increment per accepted valid pixel; width $clog2(IMAGE_LEN*IMAGE_HEIGHT+1).
REQ-019 out_cnt SHALL increment per cycle with flt_valid_i=1 in STREAM, including the cycle of the last input.
REQ-020 STREAM -> CHECK in the cycle after in_cnt reaches IMAGE_LEN*IMAGE_HEIGHT; valid arriving in that following cycle is dropped.
REQ-021 CHECK: if out_cnt != (IMAGE_LEN-1)*(IMAGE_HEIGHT-1), set err_o; next state DONE.
REQ-022 DONE: done_o=1 for one cycle; next state IDLE.
REQ-023 busy_o=1 in CLEAR, STREAM and CHECK; busy_o=0 in IDLE and DONE.
REQ-024 start_i SHALL be ignored in every state except IDLE, including in DONE.
REQ-025 err_o SHALL clear only on the CLEAR state or on rst; it holds across DONE and IDLE.
REQ-026 Counters SHALL saturate, never wrap; flt_valid_i outside STREAM is ignored.

Reset
REQ-027 rst SHALL force state IDLE and clear in_cnt, out_cnt and err_o.
REQ-028 In the cycle after rst, done_o=0, busy_o=0, flt_if.valid=0 and flt_rst_o=0.
REQ-029 rst mid-frame SHALL abort the frame with no done_o pulse; the next start_i begins a fresh frame.

Structure
REQ-030 State enum type and the expected-count function of IMAGE_LEN and IMAGE_HEIGHT SHALL reside in median_filter_pkg.
REQ-031 Pixel type SHALL come from median_filter_pkg, reused unchanged.
REQ-032 No sub-module; a top-level wrapper instantiates median_frame_ctrl beside median_filter.

Verification (IMAGE_LEN=4, IMAGE_HEIGHT=3; expected out_cnt 6)
REQ-033 start_i, then 12 contiguous valid pixels -> flt_rst_o pulses once; 12 pixels forwarded; done_o once, 2 cycles after the 12th; err_o=0.
REQ-034 12 valids with random gaps of 0-3 cycles -> same forwarded count; done_o once; err_o=0.
REQ-035 5 source valids before start_i -> flt_if.valid stays 0; frame completes after 12 subsequent valids.
REQ-036 Model flt_valid_i forced 0 throughout a frame -> err_o=1 at CHECK; holds until next CLEAR.
REQ-037 rst after 7 pixels, then start_i and 12 pixels -> no done_o for the aborted frame; one done_o, err_o=0.
REQ-038 start_i pulsed during STREAM and in DONE -> ignored; exactly one done_o per accepted start_i.
